// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the Smith-Waterman score tracking slice.
//   - Default score and position widths used by sw_max_tracker.
//   - Tracker FSM state constants (2-bit, fixed encoding).
package sw_pkg;

  localparam int unsigned SW_DATA_WIDTH = 10;
  localparam int unsigned SW_POS_WIDTH  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sw_score_cmp.sv
// sw_score_cmp: combinational clamp and strict greater-than compare.
//   score    : incoming signed score (MSB is the sign bit)
//   best_mag : magnitude bits of the stored best (stored best is never negative)
//   clamped  : score with negative values forced to zero
//   gt       : clamped score strictly greater than the stored best
module sw_score_cmp
  import sw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SW_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] score,
  input  logic [DATA_WIDTH-2:0] best_mag,
  output logic [DATA_WIDTH-1:0] clamped,
  output logic                  gt
);

  always_comb begin
    clamped = score[DATA_WIDTH-1] ? '0 : score;
    // Both operands are non-negative here, so the sign bit carries no information.
    gt      = clamped[DATA_WIDTH-2:0] > best_mag;
  end

endmodule

// File: rtl/sw_max_tracker.sv
// sw_max_tracker: tracks the best (maximum, clamped at zero) score of an
// alignment run and the input index at which it first occurred.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : opens (or restarts) a run
//   in_valid/in_score/in_last : per-cycle block maxima from the reduction tree
//   out_valid/out_ready : result handshake
//   out_score/out_pos/out_ovf : best score, its first index, counter saturated
//   busy                : high while a run or result is outstanding
// Optional feature macro SW_MAX_TRACKER_HIT_EN adds input thresh and output
// out_hit = (out_score >= thresh), with thresh sampled on the in_last cycle.
module sw_max_tracker
  import sw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SW_DATA_WIDTH,
  parameter int unsigned POS_WIDTH  = SW_POS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_score,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic [POS_WIDTH-1:0]  out_pos,
  output logic                  out_ovf,
  output logic                  busy
`ifdef SW_MAX_TRACKER_HIT_EN
  ,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  out_hit
`endif
);

  localparam logic [POS_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            state_q,     state_d;
  logic [DATA_WIDTH-1:0] best_q,      best_d;
  logic [POS_WIDTH-1:0]  best_pos_q,  best_pos_d;
  logic [POS_WIDTH-1:0]  cnt_q,       cnt_d;
  logic                  ovf_q,       ovf_d;
  logic [DATA_WIDTH-1:0] out_score_q, out_score_d;
  logic [POS_WIDTH-1:0]  out_pos_q,   out_pos_d;
  logic                  out_ovf_q,   out_ovf_d;
`ifdef SW_MAX_TRACKER_HIT_EN
  logic                  out_hit_q,   out_hit_d;
`endif

  logic [DATA_WIDTH-1:0] clamped;
  logic                  gt;

  sw_score_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .score    (in_score),
    .best_mag (best_q[DATA_WIDTH-2:0]),
    .clamped  (clamped),
    .gt       (gt)
  );

  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    best_pos_d  = best_pos_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_score_d = out_score_q;
    out_pos_d   = out_pos_q;
    out_ovf_d   = out_ovf_q;
`ifdef SW_MAX_TRACKER_HIT_EN
    out_hit_d   = out_hit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          best_d     = '0;
          best_pos_d = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end
      end

      ST_RUN: begin
        if (start) begin
          // Restart wins over any score presented in the same cycle.
          best_d     = '0;
          best_pos_d = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end else if (in_valid) begin
          if (gt) begin
            best_d     = clamped;
            best_pos_d = cnt_q;
          end
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_last) begin
            // Result registers take the post-update values so the final
            // score is included; they then hold until the next in_last.
            state_d     = ST_DONE;
            out_score_d = best_d;
            out_pos_d   = best_pos_d;
            out_ovf_d   = ovf_d;
`ifdef SW_MAX_TRACKER_HIT_EN
            out_hit_d   = $signed(best_d) >= $signed(thresh);
`endif
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      best_q      <= '0;
      best_pos_q  <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_score_q <= '0;
      out_pos_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      best_pos_q  <= best_pos_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_score_q <= out_score_d;
      out_pos_q   <= out_pos_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

`ifdef SW_MAX_TRACKER_HIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hit_q <= 1'b0;
    end else begin
      out_hit_q <= out_hit_d;
    end
  end

  assign out_hit = out_hit_q;
`else
  // Default build: no threshold compare and no hit register.
`endif

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_score = out_score_q;
  assign out_pos   = out_pos_q;
  assign out_ovf   = out_ovf_q;

endmodule
